fetch_prefetch_unit: RTL

//  Parametrised instruction-fetch stage with a prefetch queue. Replaces the single-cycle-IMEM fetch.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_prefetch_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: default data width, the canonical
// NOP encoding, and the fetch FSM state type.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// In-order synchronous FIFO holding {pc, instruction} pairs for the fetch stage.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push_i, data_i    write one entry
//   pop_i             drop the head entry (ignored when empty)
//   clear_i           empty the FIFO; wins over push/pop in the same cycle
//   head_o            head entry, read combinationally from storage
//   count_o           current occupancy (0..DEPTH)
//   empty_o, full_o   occupancy flags
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * XLEN_DEFAULT,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic                           clear_i,
    input  logic [WIDTH-1:0]               data_i,
    output logic [WIDTH-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           empty_o,
    output logic                           full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic do_push;
    logic do_pop;

    assign do_push = push_i & ~clear_i;
    assign do_pop  = pop_i & ~clear_i & ~empty_o;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed through count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage with a prefetch queue. Issues pipelined IMEM requests
// (req/gnt/rvalid, in-order responses, variable latency), buffers {pc, instr}
// pairs and hands them to ID with valid/stall. A redirect flushes the queue and
// discards every response still in flight.
// Ports:
//   clk, reset                            clock, asynchronous active-high reset
//   IMEM_req_o / IMEM_addr_o              request valid / word-aligned address
//   IMEM_gnt_i                            request accepted this cycle
//   IMEM_rvalid_i / IMEM_rdata_i          in-order response and its instruction
//   redirect_i / redirect_pc_i            flush and restart fetch at new PC
//   stall_if_i                            ID cannot accept; hold head entry
//   PIP_valid_o / PIP_instruction_o / PIP_pc_o   head entry towards ID
module fetch_prefetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN            = XLEN_DEFAULT,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] START_ADDR      = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            IMEM_req_o,
    output logic [XLEN-1:0] IMEM_addr_o,
    input  logic            IMEM_gnt_i,
    input  logic            IMEM_rvalid_i,
    input  logic [XLEN-1:0] IMEM_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_if_i,
    output logic            PIP_valid_o,
    output logic [XLEN-1:0] PIP_instruction_o,
    output logic [XLEN-1:0] PIP_pc_o
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    fetch_state_e     state_q,       state_d;
    logic [XLEN-1:0]  fetch_pc_q,    fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q,     resp_pc_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q,     discard_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [2*XLEN-1:0] fifo_head;

    logic            rvalid_eff;
    logic            issue;
    logic            dropping;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_pc_al;
    logic [SUM_W-1:0] occupancy;

    // Responses are meaningless before the first fetch has been issued.
    assign rvalid_eff     = IMEM_rvalid_i & (state_q != IDLE);
    assign redirect_pc_al = redirect_pc_i & ~XLEN'(3);
    assign occupancy      = SUM_W'(fifo_count) + SUM_W'(outstanding_q);

    // Only issue when every in-flight response is guaranteed a FIFO slot.
    assign IMEM_req_o  = (state_q == FETCH) & ~redirect_i
                       & (occupancy < SUM_W'(DEPTH))
                       & (outstanding_q < OUT_W'(MAX_OUTSTANDING));
    assign IMEM_addr_o = fetch_pc_q;
    assign issue       = IMEM_req_o & IMEM_gnt_i;

    assign dropping = rvalid_eff & (discard_q != '0);
    assign push     = rvalid_eff & (discard_q == '0) & ~redirect_i;

    assign PIP_valid_o       = ~fifo_empty & ~redirect_i;
    assign pop               = PIP_valid_o & ~stall_if_i;
    assign PIP_instruction_o = PIP_valid_o ? fifo_head[XLEN-1:0] : XLEN'(NOP_INSTR);
    assign PIP_pc_o          = PIP_valid_o ? fifo_head[2*XLEN-1:XLEN] : '0;

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (redirect_i),
        .data_i  ({resp_pc_q, IMEM_rdata_i}),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Next-state for FSM, PCs and counters.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + OUT_W'(issue) - OUT_W'(rvalid_eff);

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_al;
            resp_pc_d  = redirect_pc_al;
            // Every response still in flight belongs to the old stream, so the
            // drop count is exactly what remains outstanding after this cycle.
            discard_d  = CNT_W'(outstanding_d);
        end else begin
            if (issue)    fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (push)     resp_pc_d  = resp_pc_q + XLEN'(4);
            if (dropping) discard_d  = discard_q - CNT_W'(1);
        end

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (redirect_i && (discard_d != '0)) state_d = DRAIN;
            DRAIN:   if (discard_d == '0) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= START_ADDR;
            resp_pc_q     <= START_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full));

    a_no_rvalid_underflow: assert property (@(posedge clk) disable iff (reset)
        !(rvalid_eff && (outstanding_q == '0)));

endmodule
